// File: rtl/cp0_regfile_pkg.sv
// Shared CP0 register numbers, exception-type codes and the commit decode helper.
// The exception codes are the same values the memory-stage decoder emits.
package cp0_regfile_pkg;

  localparam logic [4:0] CP0_REG_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_REG_COUNT    = 5'd9;
  localparam logic [4:0] CP0_REG_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_REG_STATUS   = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_REG_EPC      = 5'd14;
  localparam logic [4:0] CP0_REG_PRID     = 5'd15;
  localparam logic [4:0] CP0_REG_CONFIG   = 5'd16;

  localparam logic [31:0] EXC_INT  = 32'h0000_0001;
  localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
  localparam logic [31:0] EXC_ADES = 32'h0000_0005;
  localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
  localparam logic [31:0] EXC_BP   = 32'h0000_0009;
  localparam logic [31:0] EXC_RI   = 32'h0000_000a;
  localparam logic [31:0] EXC_OV   = 32'h0000_000c;
  localparam logic [31:0] EXC_ERET = 32'h0000_000e;

  localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

  typedef struct packed {
    logic       commit;    // enters the exception vector
    logic [4:0] code;      // Cause.ExcCode
    logic       load_bad;  // address error: capture BadVAddr
    logic       eret;
  } exc_info_t;

  function automatic exc_info_t decode_exc(input logic [31:0] excepttype);
    exc_info_t info;
    info = '0;
    case (excepttype)
      EXC_INT:  begin info.commit = 1'b1; info.code = 5'd0;  end
      EXC_ADEL: begin info.commit = 1'b1; info.code = 5'd4;  info.load_bad = 1'b1; end
      EXC_ADES: begin info.commit = 1'b1; info.code = 5'd5;  info.load_bad = 1'b1; end
      EXC_SYS:  begin info.commit = 1'b1; info.code = 5'd8;  end
      EXC_BP:   begin info.commit = 1'b1; info.code = 5'd9;  end
      EXC_RI:   begin info.commit = 1'b1; info.code = 5'd10; end
      EXC_OV:   begin info.commit = 1'b1; info.code = 5'd12; end
      EXC_ERET: info.eret = 1'b1;
      default:  info = '0;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer: Count advances every second cycle, and timer_int
// latches on Count == Compare (Compare != 0) until Compare is rewritten.
module cp0_timer
  import cp0_regfile_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timer_int
);

  logic tick;
  logic wr_count;
  logic wr_compare;

  assign wr_count   = we && (waddr == CP0_REG_COUNT);
  assign wr_compare = we && (waddr == CP0_REG_COMPARE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tick      <= 1'b0;
      count     <= '0;
      compare   <= '0;
      timer_int <= 1'b0;
    end else begin
      tick <= ~tick;
      // A software write to Count overrides that cycle's increment.
      if (wr_count)
        count <= wdata;
      else if (tick)
        count <= count + 32'd1;

      if (wr_compare) begin
        compare   <= wdata;
        timer_int <= 1'b0;
      end else if ((compare != 32'd0) && (count == compare)) begin
        timer_int <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file: MTC0 writes, exception commit, interrupt
// sampling, MFC0 read mux and the Count/Compare timer.
module cp0_regfile
  import cp0_regfile_pkg::*;
#(
  parameter logic [31:0] PRID_VAL   = 32'h0000_4220,
  parameter logic [31:0] CONFIG_VAL = 32'h0000_8000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_i,
  output logic [31:0] rdata_o,
  input  logic [5:0]  int_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] pc_i,
  input  logic        is_in_delayslot_i,
  input  logic [31:0] bad_addr_i,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] badvaddr_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        timer_int_o
);

  logic [31:0] status;
  logic [31:0] cause;
  logic [31:0] epc;
  logic [31:0] badvaddr;
  logic [31:0] count;
  logic [31:0] compare;
  logic        timer_int;
  exc_info_t   exc;

  cp0_timer u_timer (
    .clk       (clk),
    .resetn    (resetn),
    .we        (we_i),
    .waddr     (waddr_i),
    .wdata     (wdata_i),
    .count     (count),
    .compare   (compare),
    .timer_int (timer_int)
  );

  assign exc = decode_exc(excepttype_i);

  // MTC0 updates are issued first so that the exception's assignments to the
  // same bits, placed later in the block, win on any overlap.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      status   <= STATUS_RESET;
      cause    <= '0;
      epc      <= '0;
      badvaddr <= '0;
    end else begin
      cause[15:10] <= {int_i[5] | timer_int, int_i[4:0]};
      cause[30]    <= timer_int;

      if (we_i) begin
        case (waddr_i)
          CP0_REG_STATUS: status     <= (status & ~STATUS_WMASK) | (wdata_i & STATUS_WMASK);
          CP0_REG_CAUSE:  cause[9:8] <= wdata_i[9:8];
          CP0_REG_EPC:    epc        <= wdata_i;
          default: ;
        endcase
      end

      if (exc.commit) begin
        cause[6:2] <= exc.code;
        // A nested exception keeps the original return point and BD flag.
        if (!status[1]) begin
          epc       <= is_in_delayslot_i ? (pc_i - 32'd4) : pc_i;
          cause[31] <= is_in_delayslot_i;
        end
        status[1] <= 1'b1;
        if (exc.load_bad)
          badvaddr <= bad_addr_i;
      end else if (exc.eret) begin
        status[1] <= 1'b0;
      end
    end
  end

  always_comb begin
    rdata_o = '0;
    case (raddr_i)
      CP0_REG_BADVADDR: rdata_o = badvaddr;
      CP0_REG_COUNT:    rdata_o = count;
      CP0_REG_COMPARE:  rdata_o = compare;
      CP0_REG_STATUS:   rdata_o = status;
      CP0_REG_CAUSE:    rdata_o = cause;
      CP0_REG_EPC:      rdata_o = epc;
      CP0_REG_PRID:     rdata_o = PRID_VAL;
      CP0_REG_CONFIG:   rdata_o = CONFIG_VAL;
      default:          rdata_o = '0;
    endcase
  end

  assign status_o    = status;
  assign cause_o     = cause;
  assign epc_o       = epc;
  assign badvaddr_o  = badvaddr;
  assign count_o     = count;
  assign compare_o   = compare;
  assign timer_int_o = timer_int;

endmodule

// File: doc/cp0_regfile.md
# cp0_regfile

Coprocessor-0 register file for the MIPS pipeline: it holds Status, Cause, EPC, BadVAddr, Count, Compare, PRId and Config. It commits the exception type and target chosen by the memory-stage exception decoder, and it performs MTC0 writes from writeback. It feeds the live Status, Cause and EPC values back to that decoder. It also sits in the register-read path for MFC0 and generates the timer interrupt.

## Interface
- PRID_VAL, 32'h0000_4220, constant PRId value
- CONFIG_VAL, 32'h0000_8000, constant Config value
- clk  in  1  system clock
- resetn  in  1  reset; asynchronous, active-low
- we_i  in  1  MTC0 write enable (writeback stage)
- waddr_i  in  5  MTC0 destination register number
- wdata_i  in  32  MTC0 write data
- raddr_i  in  5  MFC0 source register number
- rdata_o  out  32  MFC0 read data (combinational)
- int_i  in  6  external hardware interrupt lines, level-sensitive
- excepttype_i  in  32  committed exception code from decoder (0 = none)
- pc_i  in  32  PC of the excepting instruction
- is_in_delayslot_i  in  1  excepting instruction is in a branch delay slot
- bad_addr_i  in  32  faulting address for AdEL/AdES
- status_o, cause_o, epc_o, badvaddr_o, count_o, compare_o  out  32 each  registered values
- timer_int_o  out  1  timer interrupt pending

## Operation
**Register numbers:**
- BadVAddr = 8
- Count = 9
- Compare = 11
- Status = 12
- Cause = 13
- EPC = 14
- PRId = 15
- Config = 16

**Reads:** rdata_o is driven from the register currently addressed by raddr_i. Unmapped addresses read 0.

**MTC0 write masks:**
- Status: only IM[15:8], EXL[1] and IE[0] are writable; all other bits hold.
- Cause: only IP[9:8] (software interrupts) is writable.
- EPC, Count and Compare: full 32-bit write.
- BadVAddr, PRId and Config: read-only; writes are ignored.
- A write to Compare clears timer_int_o.

**Hardware interrupt sampling:**
- Every cycle, Cause.IP[15:10] <= {int_i[5] | timer_int_o, int_i[4:0]}.
- Cause.TI[30] <= timer_int_o.

**Timer:**
- Count increments by 1 every second cycle, using an internal tick toggle. The tick toggle resets to 0.
- timer_int_o sets when Count == Compare and Compare != 0.
- timer_int_o is sticky until Compare is written or reset.

**Exception commit** (excepttype_i nonzero, sampled at the clock edge):
- 0x01 Int, 0x04 AdEL, 0x05 AdES, 0x08 Sys, 0x09 Bp, 0x0a RI, 0x0c Ov:
  - Cause.ExcCode[6:2] <= 0, 4, 5, 8, 9, 10, 12 respectively.
  - If Status.EXL == 0: EPC <= is_in_delayslot_i ? pc_i - 4 : pc_i, and Cause.BD[31] <= is_in_delayslot_i.
  - If Status.EXL == 1: EPC and BD hold.
  - Status.EXL <= 1.
- AdEL and AdES additionally load BadVAddr <= bad_addr_i.
- 0x0e ERET: Status.EXL <= 0; nothing else changes.
- Any other nonzero code is ignored.

**Simultaneous events:**
- An exception commit and an MTC0 in the same cycle: the exception's field updates take priority on overlapping fields. Non-overlapping MTC0 fields still write.
- An MTC0 to Count in a tick cycle: the written value wins and the increment is dropped.
- Count wraps from 32'hFFFF_FFFF to 0 with no flag.

## Timing
**Reset values** (while resetn is low, asynchronously):
- Status = 32'h0040_0000 (BEV = 1).
- Cause, EPC, BadVAddr, Count and Compare = 0.
- timer_int_o = 0.

**Latency:**
- Writes, commits and interrupt sampling become visible on the outputs 1 cycle after the edge.
- rdata_o has 0-cycle read latency. It does not bypass a same-cycle write; the decoder performs its own writeback forwarding.
- External interrupts appear in Cause.IP 1 cycle after int_i changes.
- timer_int_o asserts 1 cycle after Count == Compare is reached.

**Reset mid-operation:** all state, including the tick phase, returns to its reset value immediately.

## Structure
**Shared constants in defines2.vh:**
- `CP0_REG_BADVADDR/COUNT/COMPARE/STATUS/CAUSE/EPC/PRID/CONFIG`.
- Exception-type codes `EXC_INT/ADEL/ADES/SYS/BP/RI/OV/ERET` (32-bit). These are shared with the exception decoder.

**Sub-module:** `cp0_timer` is a natural split. It holds Count, Compare, the tick toggle and timer_int. It takes the write ports and exports count, compare and timer_int.

## Test plan
- **Reset then read:** release resetn, then read 12 → 32'h0040_0000, read 13 → 0, read 16 → 32'h0000_8000.
- **Timer:** write Compare = 5 with Count = 0.
  - Count reaches 5 after 10 cycles and timer_int_o rises 1 cycle later.
  - Cause[15] and Cause[30] read 1.
  - Writing Compare clears timer_int_o.
- **Syscall in delay slot:** excepttype 0x08, pc 32'hBFC0_0104, delayslot 1, EXL 0 → EPC = 32'hBFC0_0100, Cause.BD = 1, ExcCode = 8, EXL = 1.
- **Nested exception:** with EXL = 1, commit 0x0c at pc 32'h8000_0010 → ExcCode = 12, EPC unchanged.
  - A following 0x0e clears EXL.
- **AdEL:** AdEL with bad_addr 32'h8000_0003 → BadVAddr = 32'h8000_0003, ExcCode = 4.
  - A same-cycle MTC0 to Status IE = 1 also lands, so Status = 32'h0040_0003.
- **Write masks:** MTC0 Status = 32'hFFFF_FFFF → 32'h0040_FF03. MTC0 Cause = 32'hFFFF_FFFF → only bits 9:8 set.
